// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: command/response sequencer between a byte UART and the control
// logic. The receive side assembles two bytes (high first) into a 16-bit
// command and abandons a half-received frame after an inter-byte timeout. The
// transmit side sends a 16-bit response as two bytes (high first).
module uart_cmd_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [15:0] resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  typedef enum logic {
    R_HI = 1'b0,
    R_LO = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HI   = 2'd1,
    T_LO   = 2'd2
  } tx_state_t;

  // Last counter value before a partial frame is declared dead.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  // ---------------------------------------------------------------------------
  // Receive path state
  // ---------------------------------------------------------------------------
  rx_state_t        rx_state_q, rx_state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;

  // ---------------------------------------------------------------------------
  // Transmit path state
  // ---------------------------------------------------------------------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        tx_busy_q, tx_busy_d;
  logic        resp_sent_q, resp_sent_d;
  logic        tx_ack_s;

  // Every byte is consumed the cycle it is presented, in either RX state.
  assign clr_rx_rdy = rx_rdy;

  // The UART drops tx_done only after it sees trmt, so tx_done is stale
  // during the trmt cycle and must not be taken as completion.
  assign tx_ack_s = tx_done & ~trmt_q;

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;

  // RX next-state: byte assembly, ready flag handling and inter-byte timeout.
  always_comb begin
    rx_state_d  = rx_state_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    case (rx_state_q)
      R_HI: begin
        if (rx_rdy) begin
          // New frame: high byte overwrites, any pending command is dropped.
          cmd_d[15:8] = rx_data;
          cmd_rdy_d   = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          rx_state_d  = R_LO;
        end else if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
        end else begin
          cmd_rdy_d = cmd_rdy_q;
        end
      end
      R_LO: begin
        if (rx_rdy) begin
          // Completing the frame takes priority over a same-cycle clear
          // and over a timeout expiring in this very cycle.
          cmd_d[7:0] = rx_data;
          cmd_rdy_d  = 1'b1;
          rx_state_d = R_HI;
        end else begin
          if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
          end else begin
            cmd_rdy_d = cmd_rdy_q;
          end
          if (cnt_q == CNT_LAST) begin
            // Stale high byte stays in cmd; the host must resend a full frame.
            rx_state_d  = R_HI;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        rx_state_d = R_HI;
      end
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= R_HI;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // TX next-state: response serialisation, one trmt pulse per byte.
  always_comb begin
    tx_state_d  = tx_state_q;
    lo_byte_d   = lo_byte_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (send_resp) begin
          // Capture the whole word now so later resp changes cannot leak in.
          lo_byte_d  = resp[7:0];
          tx_data_d  = resp[15:8];
          trmt_d     = 1'b1;
          tx_busy_d  = 1'b1;
          tx_state_d = T_HI;
        end else begin
          tx_busy_d = 1'b0;
        end
      end
      T_HI: begin
        if (tx_ack_s) begin
          tx_data_d  = lo_byte_q;
          trmt_d     = 1'b1;
          tx_state_d = T_LO;
        end else begin
          tx_state_d = T_HI;
        end
      end
      T_LO: begin
        if (tx_ack_s) begin
          resp_sent_d = 1'b1;
          tx_busy_d   = 1'b0;
          tx_state_d  = T_IDLE;
        end else begin
          tx_state_d = T_LO;
        end
      end
      default: begin
        tx_busy_d  = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  // TX state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= T_IDLE;
      lo_byte_q   <= 8'h00;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      lo_byte_q   <= lo_byte_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Scoreboard bench for uart_cmd_seq: stimulus tasks push expected events,
// one monitor process compares them as the DUT presents them.
module tb_uart_cmd_seq;

  localparam int TO = 50;
  localparam int CW = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b1;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic [15:0] resp = 16'h0000;
  logic        send_resp = 1'b0;
  logic        tx_busy;
  logic        resp_sent;

  uart_cmd_seq #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
    .resp(resp), .send_resp(send_resp), .tx_busy(tx_busy), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  // absolute count of rising edges
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [15:0] word; int at; } cmd_exp_t;
  cmd_exp_t    exp_cmd_q[$];
  int          exp_ferr_q[$];
  logic [7:0]  exp_tx_q[$];
  int          sent_pending = 0;

  // reference model of the receive framing
  bit          have_hi = 1'b0;
  logic [7:0]  hi_b = 8'h00;
  int          hi_edge = 0;
  int          rx_bytes = 0;
  int          clr_seen = 0;
  int          trmt_cnt = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One UART byte: rx_rdy for one cycle (UART clears it on clr_rx_rdy).
  task automatic send_byte(input logic [7:0] b, input bit with_clr);
    int n;
    cmd_exp_t e;
    @(posedge clk); #1;
    n = cyc + 1;
    if (have_hi && (n - hi_edge) <= TO) begin
      e.word = {hi_b, b};
      e.at   = n;
      exp_cmd_q.push_back(e);
      have_hi = 1'b0;
      void'(exp_ferr_q.pop_back());
    end else begin
      have_hi = 1'b1;
      hi_b    = b;
      hi_edge = n;
      exp_ferr_q.push_back(n + TO);
    end
    rx_data = b;
    rx_rdy  = 1'b1;
    clr_cmd_rdy = with_clr;
    rx_bytes++;
    #1 chk_eq("clr_rx_rdy", 32'(clr_rx_rdy), 32'd1);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int k = 0;
    while ((exp_tx_q.size() != 0 || sent_pending != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      note_fail("tx_idle_timeout", 32'(exp_tx_q.size()), 32'd0);
      exp_tx_q.delete();
      sent_pending = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [15:0] w, input bit poke_busy);
    wait_tx_idle();
    resp = w;
    send_resp = 1'b1;
    exp_tx_q.push_back(w[15:8]);
    exp_tx_q.push_back(w[7:0]);
    sent_pending++;
    @(posedge clk); #1;
    send_resp = 1'b0;
    resp = 16'($urandom);
    if (poke_busy) begin
      @(posedge clk); #1;
      resp = 16'h0000;
      send_resp = 1'b1;
      chk_eq("tx_busy_held", 32'(tx_busy), 32'd1);
      @(posedge clk); #1;
      send_resp = 1'b0;
    end
  endtask

  // send_resp held through two complete transfers of the same word
  task automatic send_held(input logic [15:0] w);
    int base;
    int k = 0;
    wait_tx_idle();
    base = trmt_cnt;
    resp = w;
    send_resp = 1'b1;
    repeat (2) begin
      exp_tx_q.push_back(w[15:8]);
      exp_tx_q.push_back(w[7:0]);
    end
    sent_pending += 2;
    while (trmt_cnt < base + 3 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 400) note_fail("held_timeout", 32'(trmt_cnt - base), 32'd3);
    send_resp = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk_eq({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk_eq({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd0);
    chk_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk_eq({tag, "_trmt"}, 32'(trmt), 32'd0);
    chk_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk_eq({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
    chk_eq({tag, "_resp_sent"}, 32'(resp_sent), 32'd0);
    chk_eq({tag, "_clr_rx_rdy"}, 32'(clr_rx_rdy), 32'd0);
  endtask

  // UART transmitter model: drops tx_done the edge after trmt, raises it later
  initial begin : uart_tx_model
    logic t;
    int cd;
    cd = 0;
    forever begin
      @(negedge clk);
      t = trmt;
      @(posedge clk); #1;
      if (!rst_n) begin
        tx_done = 1'b1;
        cd = 0;
      end else if (t) begin
        tx_done = 1'b0;
        cd = int'($urandom_range(6, 2));
      end else if (!tx_done) begin
        cd--;
        if (cd <= 0) tx_done = 1'b1;
      end
    end
  end

  // Monitor: compares DUT output events against the scoreboard queues
  initial begin : monitor
    bit prev_cmd_rdy;
    bit prev_trmt;
    logic [7:0] last_tx;
    cmd_exp_t e;
    prev_cmd_rdy = 1'b0;
    prev_trmt = 1'b0;
    last_tx = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cmd_rdy = 1'b0;
        prev_trmt = 1'b0;
        last_tx = 8'h00;
      end else begin
        if (clr_rx_rdy) clr_seen++;
        if (cmd_rdy && !prev_cmd_rdy) begin
          if (exp_cmd_q.size() == 0) begin
            note_fail("cmd_unexpected", 32'(cmd), 32'd0);
          end else begin
            e = exp_cmd_q.pop_front();
            chk_eq("cmd_value", 32'(cmd), 32'(e.word));
            chk_eq("cmd_rdy_cycle", 32'(cyc), 32'(e.at));
          end
        end
        prev_cmd_rdy = cmd_rdy;
        if (frame_err) begin
          if (exp_ferr_q.size() > 0 && exp_ferr_q[0] == cyc) begin
            void'(exp_ferr_q.pop_front());
            chk_eq("frame_err_cycle", 32'(cyc), 32'(cyc));
          end else begin
            note_fail("frame_err_unexpected", 32'(cyc), 32'(exp_ferr_q.size() > 0 ? exp_ferr_q[0] : 0));
          end
        end else if (exp_ferr_q.size() > 0 && exp_ferr_q[0] < cyc) begin
          note_fail("frame_err_missing", 32'(cyc), 32'(exp_ferr_q[0]));
          void'(exp_ferr_q.pop_front());
        end
        if (trmt) begin
          trmt_cnt++;
          chk_eq("trmt_width", 32'(prev_trmt), 32'd0);
          chk_eq("tx_busy_on_trmt", 32'(tx_busy), 32'd1);
          if (exp_tx_q.size() == 0) begin
            note_fail("trmt_unexpected", 32'(tx_data), 32'd0);
          end else begin
            chk_eq("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
          end
          last_tx = tx_data;
        end else if (tx_data !== last_tx) begin
          note_fail("tx_data_hold", 32'(tx_data), 32'(last_tx));
          last_tx = tx_data;
        end
        prev_trmt = trmt;
        if (resp_sent) begin
          if (sent_pending > 0) begin
            sent_pending--;
            chk_eq("tx_busy_after_sent", 32'(tx_busy), 32'd0);
          end else begin
            note_fail("resp_sent_unexpected", 32'd1, 32'd0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic frame
    send_byte(8'hA5, 1'b0);
    idle(3);
    send_byte(8'h3C, 1'b0);
    chk_eq("cmd_a53c", 32'(cmd), 32'hA53C);

    // consumer clear, then next frame
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    chk_eq("cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk_eq("cmd_1234_rdy", 32'(cmd_rdy), 32'd1);

    // new high byte drops a pending cmd_rdy
    send_byte(8'h9D, 1'b0);
    chk_eq("hi_drops_rdy", 32'(cmd_rdy), 32'd0);
    // clear coinciding with low byte: set wins
    send_byte(8'h4E, 1'b1);
    chk_eq("set_wins", 32'(cmd_rdy), 32'd1);

    // timeout: lone 0x77 then 60 idle cycles
    send_byte(8'h77, 1'b0);
    idle(60);
    chk_eq("ferr_drained", 32'(exp_ferr_q.size()), 32'd0);
    chk_eq("stale_hi", 32'(cmd[15:8]), 32'h77);
    chk_eq("stale_rdy", 32'(cmd_rdy), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);

    // low byte on the exact expiry cycle wins; one cycle later times out
    send_byte(8'hC1, 1'b0);
    idle(TO - 2);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hD1, 1'b0);
    idle(TO - 1);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);

    // response path: BEEF with a busy-time request that must be ignored
    send_word(16'hBEEF, 1'b1);
    send_held(16'h5AC3);

    // randomized full-duplex traffic
    fork
      begin : rx_rand
        for (int i = 0; i < 25; i++) begin
          int r;
          r = int'($urandom_range(9, 0));
          if (r < 6) begin
            send_byte(8'($urandom), 1'b0);
            idle(r == 0 ? int'($urandom_range(TO + 8, TO - 4)) : int'($urandom_range(10, 0)));
            send_byte(8'($urandom), 1'($urandom_range(1, 0)));
          end else if (r == 6) begin
            clr_cmd_rdy = 1'b1;
            @(posedge clk); #1;
            clr_cmd_rdy = 1'b0;
          end else if (r == 7) begin
            send_byte(8'($urandom), 1'b0);
            idle(TO + 3);
          end else begin
            idle(int'($urandom_range(5, 0)));
          end
        end
      end
      begin : tx_rand
        for (int j = 0; j < 12; j++) begin
          if (j == 5) send_held(16'($urandom));
          else send_word(16'($urandom), 1'($urandom_range(1, 0)));
        end
      end
    join
    wait_tx_idle();
    idle(TO + 5);

    // reset while in R_LO and T_HI
    send_byte(8'hE7, 1'b0);
    resp = 16'h1357;
    send_resp = 1'b1;
    exp_tx_q.push_back(8'h13);
    @(posedge clk); #1;
    send_resp = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    exp_cmd_q.delete();
    exp_ferr_q.delete();
    exp_tx_q.delete();
    sent_pending = 0;
    have_hi = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    chk_eq("cmd_55aa", 32'(cmd), 32'h55AA);
    send_word(16'h0F0F, 1'b0);
    wait_tx_idle();
    idle(TO + 5);

    chk_eq("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk_eq("ferr_q_drained", 32'(exp_ferr_q.size()), 32'd0);
    chk_eq("tx_q_drained", 32'(exp_tx_q.size()), 32'd0);
    chk_eq("clr_rx_rdy_count", 32'(clr_seen), 32'(rx_bytes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_seq.md
Name: uart_cmd_seq

Overview:
- Command/response sequencer between the UART block (rx/tx byte handshakes) and the control logic.
- Assembles two received bytes (high byte first) into a 16-bit command. Serialises a 16-bit response as two transmitted bytes (high byte first).
- Drops a half-received command after an inter-byte timeout, so the host link resynchronises on frame boundaries.

Parameters:
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between high and low command bytes before the partial frame is discarded (minimum 2).
- CNT_W, 20, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_rdy  input  1  UART byte-received flag (level, held until cleared).
- rx_data  input  8  UART received byte, valid while rx_rdy=1.
- clr_rx_rdy  output  1  clears UART rx_rdy.
- trmt  output  1  one-cycle pulse starting a UART byte transmission.
- tx_data  output  8  byte for UART to transmit.
- tx_done  input  1  UART transmit-complete flag; deasserted by UART on trmt, held high after a byte finishes.
- cmd  output  16  assembled command.
- cmd_rdy  output  1  command valid flag.
- clr_cmd_rdy  input  1  consumer acknowledge of cmd.
- frame_err  output  1  one-cycle pulse on inter-byte timeout.
- resp  input  16  response word.
- send_resp  input  1  request to transmit resp.
- tx_busy  output  1  high while a response is in flight.
- resp_sent  output  1  one-cycle pulse when the low response byte completes.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: cmd=0, cmd_rdy=0, frame_err=0, clr_rx_rdy=0, trmt=0, tx_data=0, tx_busy=0, resp_sent=0, both FSMs in IDLE, timeout counter=0.
- RX FSM states: R_HI, R_LO.
  - clr_rx_rdy is combinational. It equals rx_rdy in both states, so every byte is consumed the cycle it is seen.
  - R_HI with rx_rdy=1: cmd[15:8]<=rx_data; cmd_rdy<=0; counter<=0; go R_LO.
  - R_LO with rx_rdy=1: cmd[7:0]<=rx_data; cmd_rdy<=1 at the same edge; go R_HI. cmd_rdy is therefore high the cycle after the low byte is accepted (latency 1).
  - R_LO with rx_rdy=0: counter increments. When counter==TIMEOUT_CYCLES-1: go R_HI, frame_err pulses for one cycle, and cmd[15:8] keeps the stale value (cmd_rdy stays 0).
  - rx_rdy and timeout expiry in the same cycle: the byte wins and no frame_err is raised.
- cmd_rdy clears on clr_cmd_rdy or on acceptance of a new high byte.
  - clr_cmd_rdy in the same cycle as a low-byte acceptance: set wins.
- cmd changes only on byte acceptance. While cmd_rdy=1, a new high byte overwrites cmd[15:8] and drops cmd_rdy (no overrun queueing).
- TX FSM states: T_IDLE, T_HI, T_LO.
  - T_IDLE with send_resp=1: latch resp[7:0] internally; tx_data<=resp[15:8]; trmt=1 for exactly one cycle; tx_busy<=1; go T_HI.
  - T_HI: wait for tx_done=1. tx_done is not sampled in the cycle trmt is high. On tx_done=1: tx_data<=latched low byte; trmt=1 for one cycle; go T_LO.
  - T_LO with tx_done=1: resp_sent pulses for one cycle; tx_busy<=0; go T_IDLE.
  - send_resp while tx_busy=1 is ignored, and later changes to resp do not affect the in-flight word.
  - send_resp may be held high. A new transfer starts the cycle after return to T_IDLE if send_resp is still high.
- tx_data holds stable from trmt until the next trmt.
- RX and TX FSMs are independent; full duplex operation is allowed.
- Reset mid-operation: all state returns immediately to reset values; no partial frame survives.

Test Plan:
- Send bytes 0xA5 then 0x3C with gap < TIMEOUT_CYCLES -> cmd=0xA53C, cmd_rdy=1 one cycle after the second byte is accepted; clr_rx_rdy pulses once per byte.
- Pulse clr_cmd_rdy, then send 0x12 0x34 -> cmd_rdy low after clr; cmd=0x1234, cmd_rdy=1.
- With TIMEOUT_CYCLES=50: send 0x77, wait 60 cycles, send 0x01 0x02 -> frame_err pulses once at cycle 50 after acceptance; final cmd=0x0102, cmd_rdy=1.
- resp=0xBEEF, pulse send_resp -> trmt with tx_data=0xBE, then after tx_done trmt with tx_data=0xEF; resp_sent pulse after second tx_done; tx_busy high throughout.
- Change resp to 0x0000 and pulse send_resp while busy -> ignored; transmitted bytes remain 0xBE, 0xEF.
- Assert rst_n=0 while in R_LO and T_HI -> all outputs return to 0 asynchronously; next frame 0x55 0xAA decodes to cmd=0x55AA.
